// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one line-granular main-memory port between an
// instruction-cache client (I) and a data-cache client (D), with grant counters.
module mem_line_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 7,
  parameter int CNT_W         = 16,
  localparam int LW           = 32 << LINE_ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_rd_req,
  input  logic                i_wr_req,
  input  logic [ADDR_LEN-1:0] i_addr,
  input  logic [LW-1:0]       i_wr_line,
  output logic                i_gnt,
  output logic [LW-1:0]       i_rd_line,
  input  logic                d_rd_req,
  input  logic                d_wr_req,
  input  logic [ADDR_LEN-1:0] d_addr,
  input  logic [LW-1:0]       d_wr_line,
  output logic                d_gnt,
  output logic [LW-1:0]       d_rd_line,
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [LW-1:0]       mem_wr_line,
  input  logic [LW-1:0]       mem_rd_line,
  input  logic                mem_gnt,
  output logic                busy,
  output logic [CNT_W-1:0]    i_grant_cnt,
  output logic [CNT_W-1:0]    d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_LEN-1:0] op_addr_q, op_addr_d;
  logic [LW-1:0]       op_line_q, op_line_d;
  logic [CNT_W-1:0]    i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]    d_cnt_q, d_cnt_d;

  logic i_req, d_req;
  assign i_req = i_rd_req | i_wr_req;
  assign d_req = d_rd_req | d_wr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      op_wr_q   <= 1'b0;
      op_addr_q <= '0;
      op_line_q <= '0;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      op_wr_q   <= op_wr_d;
      op_addr_q <= op_addr_d;
      op_line_q <= op_line_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    op_wr_d     = op_wr_q;
    op_addr_d   = op_addr_q;
    op_line_d   = op_line_q;
    i_cnt_d     = i_cnt_q;
    d_cnt_d     = d_cnt_q;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    mem_wr_line = '0;
    busy        = 1'b0;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    i_rd_line   = '0;
    d_rd_line   = '0;

    // Memory-side outputs come only from latched operation registers.
    if (state_q == OWN_I || state_q == OWN_D) begin
      busy        = 1'b1;
      mem_rd_req  = ~op_wr_q;
      mem_wr_req  = op_wr_q;
      mem_addr    = op_addr_q;
      mem_wr_line = op_line_q;
    end

    case (state_q)
      IDLE: begin
        // On a tie D wins unless D was served last.
        if (d_req && (!i_req || !last_d_q)) begin
          state_d   = OWN_D;
          op_wr_d   = d_wr_req;
          op_addr_d = d_addr;
          op_line_d = d_wr_line;
        end else if (i_req) begin
          state_d   = OWN_I;
          op_wr_d   = i_wr_req;
          op_addr_d = i_addr;
          op_line_d = i_wr_line;
        end
      end
      OWN_I: begin
        i_rd_line = mem_rd_line;
        if (mem_gnt) begin
          i_gnt    = 1'b1;
          state_d  = IDLE;
          last_d_d = 1'b0;
          if (i_cnt_q != '1) i_cnt_d = i_cnt_q + CNT_W'(1);
        end
      end
      OWN_D: begin
        d_rd_line = mem_rd_line;
        if (mem_gnt) begin
          d_gnt    = 1'b1;
          state_d  = IDLE;
          last_d_d = 1'b1;
          if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_line_arbiter;
  localparam int LW = 256;
  localparam int AW = 7;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } txn_t;

  logic clk, rst;
  logic i_rd_req, i_wr_req, d_rd_req, d_wr_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wr_line, d_wr_line_c, d_line_xor, d_wr_line_w;
  logic i_gnt, d_gnt, mem_rd_req, mem_wr_req, busy, mem_gnt;
  logic [LW-1:0] i_rd_line, d_rd_line, mem_wr_line, rd_pat;
  logic [AW-1:0] mem_addr;
  logic [15:0] i_grant_cnt, d_grant_cnt;
  logic s_i_gnt, s_d_gnt, s_mem_rd_req, s_mem_wr_req, s_busy;
  logic [LW-1:0] s_i_rd_line, s_d_rd_line, s_mem_wr_line;
  logic [AW-1:0] s_mem_addr;
  logic [2:0] s_i_grant_cnt, s_d_grant_cnt;

  assign d_wr_line_w = d_wr_line_c ^ d_line_xor;

  mem_line_arbiter dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_addr(i_addr), .i_wr_line(i_wr_line),
    .i_gnt(i_gnt), .i_rd_line(i_rd_line),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wr_line(d_wr_line_w),
    .d_gnt(d_gnt), .d_rd_line(d_rd_line),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wr_line(mem_wr_line), .mem_rd_line(rd_pat), .mem_gnt(mem_gnt),
    .busy(busy), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // Narrow-counter instance on the same stimulus exposes saturation quickly.
  mem_line_arbiter #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_addr(i_addr), .i_wr_line(i_wr_line),
    .i_gnt(s_i_gnt), .i_rd_line(s_i_rd_line),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wr_line(d_wr_line_w),
    .d_gnt(s_d_gnt), .d_rd_line(s_d_rd_line),
    .mem_rd_req(s_mem_rd_req), .mem_wr_req(s_mem_wr_req), .mem_addr(s_mem_addr),
    .mem_wr_line(s_mem_wr_line), .mem_rd_line(rd_pat), .mem_gnt(mem_gnt),
    .busy(s_busy), .i_grant_cnt(s_i_grant_cnt), .d_grant_cnt(s_d_grant_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model: owner 0 none, 1 I, 2 D ----------------
  int            m_own, m_ci, m_cd;
  logic          m_last_d, m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_line;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own <= 0; m_last_d <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_line <= '0;
      m_ci <= 0; m_cd <= 0;
    end else if (m_own != 0) begin
      if (mem_gnt) begin
        if (m_own == 1) m_ci <= m_ci + 1;
        else            m_cd <= m_cd + 1;
        m_last_d <= (m_own == 2);
        m_own    <= 0;
      end
    end else if ((d_rd_req | d_wr_req) && !((i_rd_req | i_wr_req) && m_last_d)) begin
      m_own <= 2; m_wr <= d_wr_req; m_addr <= d_addr; m_line <= d_wr_line_w;
    end else if (i_rd_req | i_wr_req) begin
      m_own <= 1; m_wr <= i_wr_req; m_addr <= i_addr; m_line <= i_wr_line;
    end
  end

  // ---------------- per-cycle compare ----------------
  int i_gcnt = 0, d_gcnt = 0, cyc = 0;
  int log_port[$];
  int log_cyc[$];
  logic [LW-1:0] i_last_line;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", LW'(busy), LW'(m_own != 0));
      chk("mem_rd_req", LW'(mem_rd_req), LW'(m_own != 0 && !m_wr));
      chk("mem_wr_req", LW'(mem_wr_req), LW'(m_own != 0 && m_wr));
      if (m_own != 0) begin
        chk("mem_addr", LW'(mem_addr), LW'(m_addr));
        chk("mem_wr_line", mem_wr_line, m_line);
      end
      chk("i_gnt", LW'(i_gnt), LW'(m_own == 1 && mem_gnt));
      chk("d_gnt", LW'(d_gnt), LW'(m_own == 2 && mem_gnt));
      chk("i_rd_line", i_rd_line, (m_own == 1) ? rd_pat : '0);
      chk("d_rd_line", d_rd_line, (m_own == 2) ? rd_pat : '0);
      chk("i_grant_cnt", LW'(i_grant_cnt), LW'(sat(m_ci, 16)));
      chk("d_grant_cnt", LW'(d_grant_cnt), LW'(sat(m_cd, 16)));
      chk("s_busy", LW'(s_busy), LW'(m_own != 0));
      chk("s_i_grant_cnt", LW'(s_i_grant_cnt), LW'(sat(m_ci, 3)));
      chk("s_d_grant_cnt", LW'(s_d_grant_cnt), LW'(sat(m_cd, 3)));
      if (i_gnt) begin
        i_gcnt++; log_port.push_back(1); log_cyc.push_back(cyc); i_last_line = i_rd_line;
      end
      if (d_gnt) begin
        d_gcnt++; log_port.push_back(2); log_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- memory responder ----------------
  logic resp_en, idle_pulse;
  int   mem_lat;
  int   own_cnt = 0;

  initial begin
    mem_gnt = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        mem_gnt = 1'b0; own_cnt = 0;
      end else if (mem_gnt) begin
        mem_gnt = 1'b0;
      end else if (idle_pulse) begin
        mem_gnt = 1'b1;
      end else if (resp_en && busy) begin
        own_cnt++;
        if (own_cnt >= mem_lat) begin
          mem_gnt = 1'b1; own_cnt = 0;
        end
      end
    end
  end

  // ---------------- clients: drop request after gnt, then next queued ----------------
  txn_t i_txn[64];
  txn_t d_txn[64];
  int   i_n = 0, d_n = 0, i_pos = 0, d_pos = 0, i_done = 0, d_done = 0;
  logic i_active, d_active;

  initial begin
    i_active = 1'b0; i_rd_req = 1'b0; i_wr_req = 1'b0; i_addr = '0; i_wr_line = '0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        i_active = 1'b0; i_rd_req = 1'b0; i_wr_req = 1'b0; i_pos = i_n; i_done = i_gcnt;
      end else begin
        if (i_active && i_gcnt != i_done) begin
          i_done = i_gcnt; i_active = 1'b0; i_rd_req = 1'b0; i_wr_req = 1'b0;
        end
        if (!i_active && i_pos < i_n) begin
          i_rd_req = i_txn[i_pos].rd; i_wr_req = i_txn[i_pos].wr;
          i_addr = i_txn[i_pos].addr; i_wr_line = i_txn[i_pos].line;
          i_pos++; i_active = 1'b1;
        end
      end
    end
  end

  initial begin
    d_active = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0; d_addr = '0; d_wr_line_c = '0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        d_active = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0; d_pos = d_n; d_done = d_gcnt;
      end else begin
        if (d_active && d_gcnt != d_done) begin
          d_done = d_gcnt; d_active = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
        end
        if (!d_active && d_pos < d_n) begin
          d_rd_req = d_txn[d_pos].rd; d_wr_req = d_txn[d_pos].wr;
          d_addr = d_txn[d_pos].addr; d_wr_line_c = d_txn[d_pos].line;
          d_pos++; d_active = 1'b1;
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
  endtask

  task automatic push_i(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    i_txn[i_n] = '{rd, wr, a, l}; i_n++;
  endtask

  task automatic push_d(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    d_txn[d_n] = '{rd, wr, a, l}; d_n++;
  endtask

  task automatic wait_quiet(input string nm, input int max_cyc);
    int k;
    k = 0;
    while ((i_pos < i_n || d_pos < d_n || i_active || d_active || busy) && k < max_cyc) begin
      @(negedge clk); k++;
    end
    if (k >= max_cyc) begin
      checks++; errors++;
      $display("FAIL %s timeout after %0d cycles", nm, max_cyc);
    end
  endtask

  task automatic wait_neg_until_busy(input string nm);
    int k;
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clk); k++;
    end
    if (!busy) begin
      checks++; errors++;
      $display("FAIL %s busy never rose", nm);
    end
  endtask

  int base;
  int k;

  initial begin
    rst = 1'b1; resp_en = 1'b1; idle_pulse = 1'b0; mem_lat = 4; d_line_xor = '0;
    rd_pat = {8{32'h1234_5678}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_rd_req", LW'(mem_rd_req), '0);
    chk("rst mem_wr_req", LW'(mem_wr_req), '0);
    chk("rst mem_addr", LW'(mem_addr), '0);
    chk("rst mem_wr_line", mem_wr_line, '0);
    chk("rst gnts", LW'({i_gnt, d_gnt}), '0);
    chk("rst busy", LW'(busy), '0);
    chk("rst cnts", LW'({i_grant_cnt, d_grant_cnt}), '0);
    #2 rst = 1'b0;

    // I reads 0x15 alone
    rd_pat = {8{32'hCAFE_0015}};
    base = log_port.size();
    @(posedge clk); #1;
    push_i(1'b1, 1'b0, 7'h15, '0);
    k = 0;
    while (!i_rd_req && k < 10) begin @(negedge clk); k++; end
    chk("t1 req cycle mem_rd_req", LW'(mem_rd_req), '0);
    @(negedge clk);
    chk("t1 mem_rd_req", LW'(mem_rd_req), LW'(1'b1));
    chk("t1 mem_addr", LW'(mem_addr), LW'(7'h15));
    wait_quiet("t1", 40);
    chk("t1 log size", LW'(log_port.size() - base), LW'(1));
    if (log_port.size() > base) chk("t1 port", LW'(log_port[base]), LW'(1));
    chk("t1 rd line", i_last_line, {8{32'hCAFE_0015}});
    chk("t1 i_cnt", LW'(i_grant_cnt), LW'(16'd1));
    chk("t1 d_cnt", LW'(d_grant_cnt), LW'(16'd0));

    // tie after reset: D first, then I one idle cycle + 4 later
    do_reset();
    base = log_port.size();
    push_i(1'b1, 1'b0, 7'h01, '0);
    push_d(1'b1, 1'b0, 7'h02, '0);
    wait_quiet("t2", 60);
    if (log_port.size() >= base + 2) begin
      chk("t2 first", LW'(log_port[base]), LW'(2));
      chk("t2 second", LW'(log_port[base + 1]), LW'(1));
      chk("t2 gap", LW'(log_cyc[base + 1] - log_cyc[base]), LW'(5));
    end else begin
      checks++; errors++; $display("FAIL t2 grants got=%0d want=2", log_port.size() - base);
    end
    chk("t2 i_cnt", LW'(i_grant_cnt), LW'(16'd1));
    chk("t2 d_cnt", LW'(d_grant_cnt), LW'(16'd1));

    // continuous requests on both ports
    do_reset();
    mem_lat = 2;
    base = log_port.size();
    for (int j = 0; j < 3; j++) begin
      push_i(1'b1, 1'b0, 7'(8'h40 + j), '0);
      push_d(1'b0, 1'b1, 7'(8'h50 + j), {8{32'(j)}});
    end
    wait_quiet("t3", 100);
    if (log_port.size() >= base + 6) begin
      for (int j = 0; j < 6; j++) chk($sformatf("t3 grant%0d", j), LW'(log_port[base + j]), LW'((j % 2 == 0) ? 2 : 1));
    end else begin
      checks++; errors++; $display("FAIL t3 grants got=%0d want=6", log_port.size() - base);
    end
    chk("t3 i_cnt", LW'(i_grant_cnt), LW'(16'd3));
    chk("t3 d_cnt", LW'(d_grant_cnt), LW'(16'd3));

    // D write+read together, write line changed mid-transaction
    do_reset();
    mem_lat = 5;
    push_d(1'b1, 1'b1, 7'h2A, {224'h0, 32'hDEAD_BEEF});
    wait_neg_until_busy("t4");
    d_line_xor = '1;
    k = 0;
    while (busy && k < 20) begin
      chk("t4 mem_wr_req", LW'(mem_wr_req), LW'(1'b1));
      chk("t4 mem_rd_req", LW'(mem_rd_req), '0);
      chk("t4 word0", LW'(mem_wr_line[31:0]), LW'(32'hDEAD_BEEF));
      chk("t4 mem_addr", LW'(mem_addr), LW'(7'h2A));
      @(negedge clk); k++;
    end
    wait_quiet("t4", 40);
    d_line_xor = '0;
    chk("t4 d_cnt", LW'(d_grant_cnt), LW'(16'd1));

    // reset while owned by I
    do_reset();
    resp_en = 1'b0;
    push_i(1'b1, 1'b0, 7'h33, '0);
    wait_neg_until_busy("t5");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5 mem_rd_req", LW'(mem_rd_req), '0);
    chk("t5 busy", LW'(busy), '0);
    chk("t5 i_gnt", LW'(i_gnt), '0);
    chk("t5 cnts", LW'({i_grant_cnt, d_grant_cnt}), '0);
    @(posedge clk); #3 rst = 1'b0;
    resp_en = 1'b1; mem_lat = 3;
    base = log_port.size();
    push_i(1'b1, 1'b0, 7'h34, '0);
    wait_neg_until_busy("t5b");
    chk("t5 re-arb addr", LW'(mem_addr), LW'(7'h34));
    wait_quiet("t5b", 40);
    chk("t5 grants", LW'(log_port.size() - base), LW'(1));
    chk("t5 i_cnt", LW'(i_grant_cnt), LW'(16'd1));

    // mem_gnt while idle is ignored
    resp_en = 1'b0;
    @(posedge clk); #1 idle_pulse = 1'b1;
    @(negedge clk);
    chk("t6 mem_gnt seen", LW'(mem_gnt), LW'(1'b1));
    chk("t6 gnts", LW'({i_gnt, d_gnt}), '0);
    idle_pulse = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6 i_cnt", LW'(i_grant_cnt), LW'(16'd1));
    chk("t6 d_cnt", LW'(d_grant_cnt), LW'(16'd0));

    // saturation: 9 D transactions on a 3-bit counter
    do_reset();
    resp_en = 1'b1; mem_lat = 1;
    for (int j = 0; j < 9; j++) push_d(1'b1, 1'b0, 7'(j), '0);
    wait_quiet("t7", 200);
    chk("t7 d_cnt16", LW'(d_grant_cnt), LW'(16'd9));
    chk("t7 d_cnt3", LW'(s_d_grant_cnt), LW'(3'h7));
    chk("t7 i_cnt3", LW'(s_i_grant_cnt), LW'(3'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares one line-granular main-memory port (main_mem gnt/addr/rd_req/rd_line/wr_req/wr_line protocol) between two cache clients: port I (instruction cache) and port D (data cache).
- Sits between the two cache instances and a single main_mem instance.
- Grants one whole line transaction at a time, using round-robin between the ports.
- Latches the winning request, holds the memory port until the memory gnt pulse, and routes the gnt and read line back to the owner.
- Keeps per-port grant counters for performance monitoring.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; line width LW = 32 << LINE_ADDR_LEN bits.
- ADDR_LEN, 7, line address width (tag + set).
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_rd_req  in  1  port I line read request
- i_wr_req  in  1  port I line write request
- i_addr  in  ADDR_LEN  port I line address
- i_wr_line  in  LW  port I write line; word k is in bits [32k+31:32k]
- i_gnt  out  1  port I completion pulse
- i_rd_line  out  LW  port I read line
- d_rd_req, d_wr_req, d_addr, d_wr_line, d_gnt, d_rd_line: same as port I, for port D
- mem_rd_req  out  1  memory read request
- mem_wr_req  out  1  memory write request
- mem_addr  out  ADDR_LEN  memory line address
- mem_wr_line  out  LW  memory write line
- mem_rd_line  in  LW  memory read line
- mem_gnt  in  1  memory completion pulse, one cycle
- busy  out  1  high while a transaction is owned
- i_grant_cnt  out  CNT_W  transactions completed for port I
- d_grant_cnt  out  CNT_W  transactions completed for port D

Behaviour:
- States: IDLE, OWN_I, OWN_D. Registers: last_d (last port served was D), op_wr, op_addr, op_line, the two counters.
- Reset, asynchronous: state=IDLE, last_d=0 (D wins the first tie), op registers=0, counters=0.
  - Outputs at reset: mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wr_line=0, i_gnt=0, d_gnt=0, busy=0.
- Request of a port: rd_req | wr_req. If both are set, the transaction is a write (op_wr=1).
- IDLE:
  - Exactly one port requesting: that port wins.
  - Both requesting: D wins if last_d=0, otherwise I wins.
  - On the winning edge: latch op_wr, op_addr and op_line (from wr_line) from the winner; go to OWN_x.
  - No request: stay in IDLE. Memory request outputs are 0 in IDLE.
- OWN_x:
  - mem_rd_req = ~op_wr; mem_wr_req = op_wr; mem_addr = op_addr; mem_wr_line = op_line; busy = 1.
  - Memory outputs depend only on registers. Client inputs are ignored while owned, so a client changing or dropping its request mid-transaction has no effect.
  - When mem_gnt=1: x_gnt = 1 in the same cycle (combinational); next state IDLE; last_d = (x==D); x_grant_cnt increments.
  - Counters saturate at all-ones.
- Read data: i_rd_line = mem_rd_line while in OWN_I, else 0; d_rd_line likewise for OWN_D. Clients sample it on their gnt cycle.
- Latency:
  - Request visible in IDLE at edge N; memory request high from cycle N+1.
  - mem_gnt in cycle M gives client gnt in cycle M and IDLE in cycle M+1.
  - A new arbitration can be granted at the edge ending cycle M+1, so there is at least one dead cycle between transactions.
- The client must drop its request the cycle after its gnt; its cache FSM does this. A request still present in IDLE is treated as a new transaction.
- mem_gnt in IDLE is ignored: no client gnt, no counter change.
- x_gnt is never asserted outside OWN_x, and i_gnt and d_gnt are never asserted in the same cycle.
- Reset mid-transaction: memory requests drop immediately (asynchronous); the in-flight transaction is abandoned with no client gnt.

Test Plan:
- Port I reads addr 0x15 alone, memory gnt 4 cycles after request:
  - mem_rd_req high from cycle 1, mem_addr=0x15.
  - i_gnt pulses in the mem_gnt cycle with i_rd_line=mem_rd_line; i_grant_cnt=1.
  - d_gnt stays 0 throughout.
- Both ports request in the same cycle after reset:
  - D is served first, then I after one IDLE cycle.
  - Final counters: d_grant_cnt=1, i_grant_cnt=1.
- Both ports hold requests continuously for 6 transactions:
  - Grants strictly alternate D, I, D, I, D, I.
  - Each counter ends at 3.
- Port D asserts wr_req and rd_req together with wr_line word0=0xDEADBEEF and addr 0x2A, then changes d_wr_line mid-transaction:
  - mem_wr_req=1 and mem_rd_req=0 for the whole transaction.
  - mem_wr_line word0 stays 0xDEADBEEF.
- rst pulsed while in OWN_I before mem_gnt:
  - mem_rd_req=0 immediately and no i_gnt.
  - Counters are 0.
  - The next request is re-arbitrated from IDLE.
- mem_gnt pulsed while IDLE: no client gnt and counters unchanged. Separately, force d_grant_cnt to 0xFFFF and complete another D transaction: the counter stays 0xFFFF.
